// File: rtl/tam_pkg.sv
// ---------------------------------------------------------------------------
// tam_pkg
// Shared types and helpers for the toggle activity monitor.
//   state_e   : monitor state (PRIME waits for a reference sample, RUN counts)
//   rec_t     : one activity record as stored in the record FIFO
//   bits_for  : number of bits needed to hold the value n
//   popcount  : number of set bits in a (zero-extended) probe difference
// Record fields are held at a fixed maximum width so that a single rec_t
// serves every parameterisation; the top level narrows them on output.
// ---------------------------------------------------------------------------
package tam_pkg;

    localparam int unsigned REC_CNT_MAX_W = 32;
    localparam int unsigned REC_IDX_MAX_W = 32;
    localparam int unsigned PROBE_MAX_W   = 256;
    localparam int unsigned POP_MAX_W     = 9;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic [REC_IDX_MAX_W-1:0] index;
        logic [REC_CNT_MAX_W-1:0] count;
        logic                     sat;
        logic                     partial;
    } rec_t;

    function automatic int unsigned bits_for(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [POP_MAX_W-1:0] popcount(input logic [PROBE_MAX_W-1:0] v);
        logic [POP_MAX_W-1:0] c;
        c = '0;
        for (int i = 0; i < PROBE_MAX_W; i++) begin
            c = c + POP_MAX_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/toggle_activity_monitor_if.sv
// ---------------------------------------------------------------------------
// toggle_activity_monitor_if
// Valid/ready record stream from the monitor to the power-trace writer.
//   rec_valid    : a record is presented
//   rec_ready    : consumer accepts the presented record
//   rec_count    : toggles counted in the window
//   rec_index    : window index
//   rec_sat      : toggle accumulator saturated during the window
//   rec_partial  : window was closed early by flush
// Modports: master (monitor side), slave (consumer side).
// ---------------------------------------------------------------------------
interface toggle_activity_monitor_if #(
    parameter int CNT_W = 16,
    parameter int IDX_W = 12
);
    logic             rec_valid;
    logic             rec_ready;
    logic [CNT_W-1:0] rec_count;
    logic [IDX_W-1:0] rec_index;
    logic             rec_sat;
    logic             rec_partial;

    modport master (
        output rec_valid,
        output rec_count,
        output rec_index,
        output rec_sat,
        output rec_partial,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_count,
        input  rec_index,
        input  rec_sat,
        input  rec_partial,
        output rec_ready
    );
endinterface

// File: rtl/tam_rec_fifo.sv
// ---------------------------------------------------------------------------
// tam_rec_fifo
// Synchronous FIFO of activity records, no bypass path.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push      : write push_rec; accepted when not full or when popping
//   push_rec  : record to write
//   pop       : remove the head record (ignored when empty)
//   head_rec  : current head record (undefined when empty)
//   full      : DEPTH records held
//   empty     : no record held
// ---------------------------------------------------------------------------
module tam_rec_fifo
    import tam_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rec_t push_rec,
    input  logic pop,
    output rec_t head_rec,
    output logic full,
    output logic empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    rec_t            mem [DEPTH];
    logic            do_push;
    logic            do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                      (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    // A push into a full FIFO still succeeds when the head leaves this cycle.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign head_rec = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= push_rec;
        end
    end

endmodule

// File: rtl/toggle_activity_monitor.sv
// ---------------------------------------------------------------------------
// toggle_activity_monitor
// Samples a bus of probed nets on enabled cycles, counts bit toggles between
// consecutive samples and closes a record every WINDOW counted samples (or
// early on flush). Records are queued in a small FIFO and streamed out; a
// record arriving while the FIFO is full is dropped and counted.
//   clk         : clock
//   rst         : synchronous active-high reset
//   enable      : take a probe sample this cycle
//   probe       : observed net values
//   flush       : close the current window early and return to PRIME
//   rec         : record stream (master modport)
//   drop_count  : records lost to a full FIFO, saturates at 255
//   busy        : monitor is in RUN
// ---------------------------------------------------------------------------
module toggle_activity_monitor
    import tam_pkg::*;
#(
    parameter int WIDTH      = 34,
    parameter int CNT_W      = 16,
    parameter int WINDOW     = 1024,
    parameter int IDX_W      = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           probe,
    input  logic                       flush,
    toggle_activity_monitor_if.master  rec,
    output logic [7:0]                 drop_count,
    output logic                       busy
);

    localparam int POP_W = bits_for(WIDTH);
    localparam int CYC_W = bits_for(WINDOW);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    state_e             state;
    state_e             state_nxt;
    logic [WIDTH-1:0]   prev;
    logic [CNT_W-1:0]   acc;
    logic [CNT_W-1:0]   acc_new;
    logic               sat;
    logic               sat_new;
    logic [CYC_W-1:0]   cyc;
    logic [CYC_W-1:0]   cyc_inc;
    logic [IDX_W-1:0]   idx;
    logic [POP_MAX_W-1:0] pop_full;
    logic [POP_W-1:0]   pop;
    logic [SUM_W-1:0]   sum;
    logic               sample;
    logic               prime;
    logic               full_close;
    logic               flush_close;
    logic               push;
    logic               pop_fire;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    rec_t               push_rec;
    rec_t               head_rec;
    logic               pop_unused;
    logic               head_unused;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    // PRIME leaves on the first enabled sample; RUN returns to PRIME on any
    // flush, whether or not that flush produced a record.
    always_comb begin
        state_nxt = state;
        case (state)
            PRIME:   if (enable) state_nxt = RUN;
            RUN:     if (flush)  state_nxt = PRIME;
            default: state_nxt = PRIME;
        endcase
    end

    // Toggle accumulation for this cycle's sample, and the two ways a window
    // can close. cyc_inc already includes this cycle's sample, so a non-zero
    // value means the window has something in it worth reporting on flush.
    always_comb begin
        sample   = (state == RUN) && enable;
        prime    = (state == PRIME) && enable;
        pop_full = popcount(PROBE_MAX_W'(probe ^ prev));
        pop      = pop_full[POP_W-1:0];
        sum      = SUM_W'(acc) + SUM_W'(pop);
        acc_new  = acc;
        sat_new  = sat;
        cyc_inc  = cyc;
        if (sample) begin
            if (sum > SUM_W'(ACC_MAX)) begin
                acc_new = ACC_MAX;
                sat_new = 1'b1;
            end else begin
                acc_new = sum[CNT_W-1:0];
            end
            cyc_inc = cyc + CYC_W'(1);
        end
        full_close  = sample && (cyc_inc == CYC_W'(WINDOW));
        flush_close = flush && (state == RUN) && (cyc_inc != '0);
        push        = full_close || flush_close;
    end

    // A flush landing on the window's last sample yields a single full record.
    always_comb begin
        push_rec         = '0;
        push_rec.index   = REC_IDX_MAX_W'(idx);
        push_rec.count   = REC_CNT_MAX_W'(acc_new);
        push_rec.sat     = sat_new;
        push_rec.partial = !full_close;
    end

    assign pop_fire = !fifo_empty && rec.rec_ready;
    assign drop     = push && fifo_full && !pop_fire;

    // Window datapath. The index advances on every closed window even when
    // the record itself is dropped, so gaps in the index reveal losses.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            acc        <= '0;
            sat        <= 1'b0;
            cyc        <= '0;
            idx        <= '0;
            drop_count <= '0;
        end else begin
            if (prime || sample) begin
                prev <= probe;
            end
            if (push) begin
                acc <= '0;
                sat <= 1'b0;
                cyc <= '0;
                idx <= idx + IDX_W'(1);
            end else if (sample) begin
                acc <= acc_new;
                sat <= sat_new;
                cyc <= cyc_inc;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    tam_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_rec (push_rec),
        .pop      (pop_fire),
        .head_rec (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Head fields are forced to zero while empty so stale or uninitialised
    // FIFO storage never reaches the consumer.
    assign rec.rec_valid   = !fifo_empty;
    assign rec.rec_count   = fifo_empty ? '0 : head_rec.count[CNT_W-1:0];
    assign rec.rec_index   = fifo_empty ? '0 : head_rec.index[IDX_W-1:0];
    assign rec.rec_sat     = !fifo_empty && head_rec.sat;
    assign rec.rec_partial = !fifo_empty && head_rec.partial;
    assign busy            = (state == RUN);

    // Upper bits of the fixed-width popcount and record fields are unused
    // for narrower parameterisations.
    assign pop_unused  = ^pop_full;
    assign head_unused = ^{head_rec.count, head_rec.index};

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// ---------------------------------------------------------------------------
// tb_toggle_activity_monitor
// Two monitors (CNT_W=16 and CNT_W=4, otherwise WIDTH=8, WINDOW=4,
// FIFO_DEPTH=2) share one stimulus stream. A behavioural model keeps the
// unbounded toggle total per window and a queue of pending records; count
// and sat for each instance are derived from that total at compare time.
// ---------------------------------------------------------------------------
module tb_toggle_activity_monitor;

    localparam int WIDTH  = 8;
    localparam int WINDOW = 4;
    localparam int IDX_W  = 12;
    localparam int DEPTH  = 2;
    localparam int MAX_A  = 65535;
    localparam int MAX_B  = 15;

    typedef struct {
        int idx;
        int total;
        bit partial;
    } mrec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             flush;
    logic [WIDTH-1:0] probe;
    logic [7:0]       drop_a;
    logic [7:0]       drop_b;
    logic             busy_a;
    logic             busy_b;

    int               checks;
    int               failures;

    mrec_t            mq[$];
    bit               m_run;
    logic [WIDTH-1:0] m_prev;
    int               m_total;
    int               m_cyc;
    int               m_idx;
    int               m_drop;

    always #5 clk = ~clk;

    toggle_activity_monitor_if #(.CNT_W(16), .IDX_W(IDX_W)) if_a ();
    toggle_activity_monitor_if #(.CNT_W(4),  .IDX_W(IDX_W)) if_b ();

    toggle_activity_monitor #(
        .WIDTH(WIDTH), .CNT_W(16), .WINDOW(WINDOW), .IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .probe(probe), .flush(flush),
        .rec(if_a), .drop_count(drop_a), .busy(busy_a)
    );

    toggle_activity_monitor #(
        .WIDTH(WIDTH), .CNT_W(4), .WINDOW(WINDOW), .IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .probe(probe), .flush(flush),
        .rec(if_b), .drop_count(drop_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Effect of one clock edge with the given inputs on the expected outputs.
    task automatic model_step(input bit r, input bit e, input logic [WIDTH-1:0] p,
                              input bit f, input bit rdy);
        bit    do_pop;
        bit    push;
        bit    full;
        mrec_t nr;
        if (r) begin
            m_run = 0; m_prev = '0; m_total = 0; m_cyc = 0; m_idx = 0; m_drop = 0;
            mq.delete();
            return;
        end
        do_pop = (mq.size() > 0) && rdy;
        push   = 0;
        nr     = '{idx: 0, total: 0, partial: 0};
        if (!m_run) begin
            if (e) begin
                m_prev = p;
                m_run  = 1;
            end
        end else begin
            if (e) begin
                m_total += $countones(p ^ m_prev);
                m_cyc++;
                m_prev = p;
            end
            full = e && (m_cyc == WINDOW);
            if (full || (f && m_cyc > 0)) begin
                nr = '{idx: m_idx, total: m_total, partial: !full};
                push = 1;
                m_total = 0;
                m_cyc = 0;
                m_idx++;
            end
            if (f) m_run = 0;
        end
        if (push && !(mq.size() < DEPTH || do_pop) && m_drop < 255) m_drop++;
        if (do_pop) void'(mq.pop_front());
        if (push && (mq.size() < DEPTH)) mq.push_back(nr);
    endtask

    task automatic checkOutput();
        bit exp_valid;
        int t;
        exp_valid = (mq.size() > 0);
        check("a_valid", 32'(if_a.rec_valid), 32'(exp_valid));
        check("b_valid", 32'(if_b.rec_valid), 32'(exp_valid));
        check("a_busy",  32'(busy_a), 32'(m_run));
        check("b_busy",  32'(busy_b), 32'(m_run));
        check("a_drop",  32'(drop_a), 32'(m_drop));
        check("b_drop",  32'(drop_b), 32'(m_drop));
        if (exp_valid) begin
            t = mq[0].total;
            check("a_count",   32'(if_a.rec_count),   32'((t > MAX_A) ? MAX_A : t));
            check("b_count",   32'(if_b.rec_count),   32'((t > MAX_B) ? MAX_B : t));
            check("a_sat",     32'(if_a.rec_sat),     32'(t > MAX_A));
            check("b_sat",     32'(if_b.rec_sat),     32'(t > MAX_B));
            check("a_index",   32'(if_a.rec_index),   32'(mq[0].idx % 4096));
            check("b_index",   32'(if_b.rec_index),   32'(mq[0].idx % 4096));
            check("a_partial", 32'(if_a.rec_partial), 32'(mq[0].partial));
            check("b_partial", 32'(if_b.rec_partial), 32'(mq[0].partial));
        end
    endtask

    // Drive inputs away from the edge, advance one clock, then compare.
    task automatic applyStimulus(input bit r, input bit e, input logic [WIDTH-1:0] p,
                                 input bit f, input bit rdy);
        rst = r; enable = e; probe = p; flush = f;
        if_a.rec_ready = rdy;
        if_b.rec_ready = rdy;
        @(posedge clk);
        model_step(r, e, p, f, rdy);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        logic [WIDTH-1:0] t2 [5];
        logic [WIDTH-1:0] alt [4];
        checks = 0; failures = 0;
        m_run = 0; m_prev = '0; m_total = 0; m_cyc = 0; m_idx = 0; m_drop = 0;
        t2  = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        alt = '{8'hFF, 8'h00, 8'hFF, 8'h00};

        $display("[TB] reset with toggling probe");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, i[0] ? 8'hFF : 8'h00, i == 1, 1);
            check("rst_valid", 32'(if_a.rec_valid), 32'd0);
            check("rst_busy",  32'(busy_a), 32'd0);
            check("rst_drop",  32'(drop_a), 32'd0);
            check("rst_count", 32'(if_b.rec_count), 32'd0);
        end

        $display("[TB] single full window");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, t2[i], 0, 1);
        check("w0_valid",   32'(if_a.rec_valid),   32'd1);
        check("w0_count_a", 32'(if_a.rec_count),   32'd32);
        check("w0_index",   32'(if_a.rec_index),   32'd0);
        check("w0_sat_a",   32'(if_a.rec_sat),     32'd0);
        check("w0_partial", 32'(if_a.rec_partial), 32'd0);
        check("w0_count_b", 32'(if_b.rec_count),   32'd15);
        check("w0_sat_b",   32'(if_b.rec_sat),     32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h00, 0, 1);
        check("w1_count_b", 32'(if_b.rec_count), 32'd0);
        check("w1_sat_b",   32'(if_b.rec_sat),   32'd0);
        check("w1_index_b", 32'(if_b.rec_index), 32'd1);
        applyStimulus(0, 0, 8'h00, 0, 1);

        $display("[TB] backpressure and drop");
        applyStimulus(1, 0, 8'h00, 0, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        for (int w = 0; w < 3; w++)
            for (int s = 0; s < 4; s++) applyStimulus(0, 1, alt[s], 0, 0);
        check("bp_drop",  32'(drop_a), 32'd1);
        check("bp_valid", 32'(if_a.rec_valid), 32'd1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 0);
            check("bp_hold_index", 32'(if_a.rec_index), 32'd0);
        end
        applyStimulus(0, 0, 8'h00, 0, 1);
        check("bp_index1", 32'(if_a.rec_index), 32'd1);
        applyStimulus(0, 0, 8'h00, 0, 1);
        check("bp_empty", 32'(if_a.rec_valid), 32'd0);

        $display("[TB] flush behaviour");
        applyStimulus(1, 0, 8'h00, 0, 1);
        applyStimulus(0, 1, 8'h00, 0, 1);
        applyStimulus(0, 1, 8'h07, 0, 1);
        applyStimulus(0, 1, 8'h00, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 1);
        check("fl_count",   32'(if_a.rec_count),   32'd6);
        check("fl_partial", 32'(if_a.rec_partial), 32'd1);
        check("fl_index",   32'(if_a.rec_index),   32'd0);
        check("fl_busy",    32'(busy_a),           32'd0);
        applyStimulus(0, 1, 8'h55, 0, 1);
        check("fl_prime_busy",  32'(busy_a), 32'd1);
        check("fl_prime_valid", 32'(if_a.rec_valid), 32'd0);
        applyStimulus(0, 1, 8'hAA, 0, 1);
        applyStimulus(0, 1, 8'h55, 0, 1);
        applyStimulus(0, 1, 8'hAA, 0, 1);
        applyStimulus(0, 1, 8'h55, 0, 1);
        check("fl_next_index", 32'(if_a.rec_index), 32'd1);
        check("fl_next_count", 32'(if_a.rec_count), 32'd32);
        applyStimulus(0, 1, 8'hAA, 0, 1);
        applyStimulus(0, 1, 8'h55, 0, 1);
        applyStimulus(0, 1, 8'hAA, 0, 1);
        applyStimulus(0, 1, 8'h55, 1, 1);
        check("flfull_partial", 32'(if_a.rec_partial), 32'd0);
        check("flfull_index",   32'(if_a.rec_index),   32'd2);
        check("flfull_busy",    32'(busy_a),           32'd0);
        applyStimulus(0, 0, 8'h00, 1, 1);
        applyStimulus(0, 1, 8'h00, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 1);
        check("flempty_valid", 32'(if_a.rec_valid), 32'd0);
        check("flempty_busy",  32'(busy_a), 32'd0);
        applyStimulus(0, 1, 8'h00, 0, 1);
        applyStimulus(0, 1, 8'hFF, 1, 1);
        check("flone_count", 32'(if_a.rec_count), 32'd8);
        check("flone_index", 32'(if_a.rec_index), 32'd3);

        $display("[TB] reset mid-window");
        applyStimulus(0, 1, 8'h00, 0, 0);
        for (int s = 0; s < 4; s++) applyStimulus(0, 1, alt[s], 0, 0);
        applyStimulus(0, 1, 8'hFF, 0, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        applyStimulus(1, 1, 8'hFF, 0, 0);
        check("mr_valid", 32'(if_a.rec_valid), 32'd0);
        check("mr_busy",  32'(busy_a), 32'd0);
        applyStimulus(0, 1, 8'h00, 0, 1);
        applyStimulus(0, 1, 8'h0F, 0, 1);
        applyStimulus(0, 1, 8'hF0, 0, 1);
        applyStimulus(0, 1, 8'h0F, 0, 1);
        applyStimulus(0, 1, 8'hF0, 0, 1);
        check("mr_index", 32'(if_a.rec_index), 32'd0);
        check("mr_count", 32'(if_a.rec_count), 32'd28);

        $display("[TB] drop counter saturation");
        applyStimulus(1, 0, 8'h00, 0, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        for (int w = 0; w < 259; w++)
            for (int s = 0; s < 4; s++) applyStimulus(0, 1, alt[s], 0, 0);
        check("dsat_a", 32'(drop_a), 32'd255);
        check("dsat_b", 32'(drop_b), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
